// File: rtl/iq_burst_framer_pkg.sv
// Shared types and constants for the I/Q burst framer: FSM states,
// settings-register offsets, CTRL bit positions and the SPP reset value.
package iq_burst_framer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam int SPP_OFS   = 0;
  localparam int BURST_OFS = 1;
  localparam int CTRL_OFS  = 2;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;

  localparam logic [15:0] SPP_RESET = 16'd16;

endpackage

// File: rtl/iq_framer_skid.sv
// Two-entry AXI-Stream skid buffer: one cycle from accept to valid, full throughput,
// input ready depends only on occupancy, never on the downstream ready.
module iq_framer_skid #(
  parameter int W = 33
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_dat,
  input  logic         i_vld,
  output logic         o_rdy,
  output logic [W-1:0] o_dat,
  output logic         o_vld,
  input  logic         i_rdy
);

  logic [W-1:0] r_mem [0:1];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_rdy  = (r_cnt != 2'd2);
  assign o_vld  = (r_cnt != 2'd0);
  assign o_dat  = r_mem[r_rd_ptr];
  assign w_push = i_vld & o_rdy;
  assign w_pop  = o_vld & i_rdy;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= 2'(r_cnt + 2'd1);
        2'b01:   r_cnt <= 2'(r_cnt - 2'd1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/iq_burst_framer.sv
// Re-frames a continuous I/Q stream into SPP-sample packets, optionally N-packet bursts.
// Optional completed-packet statistics counter under IQ_BURST_FRAMER_STATS_EN.
module iq_burst_framer
  import iq_burst_framer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SR_BASE = 132
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             busy,
  output logic             burst_done,
  output logic [31:0]      rb_pkt_count
);

  localparam logic [7:0] ADDR_SPP   = 8'(SR_BASE + SPP_OFS);
  localparam logic [7:0] ADDR_BURST = 8'(SR_BASE + BURST_OFS);
  localparam logic [7:0] ADDR_CTRL  = 8'(SR_BASE + CTRL_OFS);

  state_t      r_state;
  state_t      w_nxt;
  logic [15:0] r_spp_cfg, r_burst_cfg;
  logic [15:0] r_spp_wk, r_burst_wk;
  logic [15:0] r_smp_cnt, r_pkt_cnt;
  logic [15:0] w_pkt_nxt;
  logic        w_start, w_stop, w_ctrl;
  logic        w_acc, w_last_smp, w_last, w_burst_hit;
  logic        w_skid_rdy;
  logic [WIDTH:0] w_skid_dat;
  logic        w_unused;

  assign w_unused = &{1'b0, i_tlast, set_data[31:16]};

  assign w_ctrl  = set_stb && (set_addr == ADDR_CTRL);
  assign w_stop  = w_ctrl && set_data[CTRL_STOP];
  assign w_start = w_ctrl && set_data[CTRL_START] && !set_data[CTRL_STOP];

  assign w_acc       = i_tvalid & i_tready;
  assign w_last_smp  = (r_smp_cnt == 16'(r_spp_wk - 16'd1));
  assign w_last      = w_acc & w_last_smp;
  assign w_pkt_nxt   = (r_pkt_cnt == 16'hFFFF) ? r_pkt_cnt : 16'(r_pkt_cnt + 16'd1);
  assign w_burst_hit = (r_burst_wk != 16'd0) && (w_pkt_nxt == r_burst_wk);

  // Zero SPP is clamped so a packet always holds at least one sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spp_cfg   <= SPP_RESET;
      r_burst_cfg <= 16'd0;
    end else if (set_stb) begin
      if (set_addr == ADDR_SPP)
        r_spp_cfg <= (set_data[15:0] == 16'd0) ? 16'd1 : set_data[15:0];
      if (set_addr == ADDR_BURST)
        r_burst_cfg <= set_data[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_spp_wk   <= SPP_RESET;
      r_burst_wk <= 16'd0;
      r_smp_cnt  <= 16'd0;
      r_pkt_cnt  <= 16'd0;
    end else if (clear) begin
      r_smp_cnt  <= 16'd0;
      r_pkt_cnt  <= 16'd0;
    end else if (r_state == IDLE && w_start) begin
      r_spp_wk   <= r_spp_cfg;
      r_burst_wk <= r_burst_cfg;
      r_smp_cnt  <= 16'd0;
      r_pkt_cnt  <= 16'd0;
    end else if (w_acc) begin
      if (w_last_smp) begin
        r_smp_cnt  <= 16'd0;
        r_pkt_cnt  <= w_pkt_nxt;
        r_spp_wk   <= r_spp_cfg;
        r_burst_wk <= r_burst_cfg;
      end else begin
        r_smp_cnt  <= 16'(r_smp_cnt + 16'd1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else            r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:     if (w_start) w_nxt = RUN;
      RUN: begin
        if (w_last && (w_stop || w_burst_hit)) w_nxt = IDLE;
        else if (w_stop)                       w_nxt = STOPPING;
      end
      STOPPING: if (w_last) w_nxt = IDLE;
      default:  w_nxt = IDLE;
    endcase
  end

  always_comb begin
    i_tready   = 1'b0;
    busy       = o_tvalid;
    burst_done = 1'b0;
    if (r_state != IDLE) begin
      i_tready   = w_skid_rdy;
      busy       = 1'b1;
      burst_done = w_last & w_burst_hit;
    end
  end

  iq_framer_skid #(.W(WIDTH + 1)) u_skid (
    .i_clk (clk),
    .i_rst (reset),
    .i_clr (clear),
    .i_dat ({w_last_smp, i_tdata}),
    .i_vld (w_acc),
    .o_rdy (w_skid_rdy),
    .o_dat (w_skid_dat),
    .o_vld (o_tvalid),
    .i_rdy (o_tready)
  );

  assign o_tdata = w_skid_dat[WIDTH-1:0];
  assign o_tlast = w_skid_dat[WIDTH];

`ifdef IQ_BURST_FRAMER_STATS_EN
  logic [31:0] r_pkt_stat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              r_pkt_stat <= 32'd0;
    else if (clear)                         r_pkt_stat <= 32'd0;
    else if (o_tvalid & o_tready & o_tlast) r_pkt_stat <= 32'(r_pkt_stat + 32'd1);
  end
  assign rb_pkt_count = r_pkt_stat;
`else
  assign rb_pkt_count = 32'd0;
`endif

endmodule

// File: tb/tb_iq_burst_framer.sv
// Directed bench for iq_burst_framer: counting tone source, output monitor with
// packet-length, sequence and stall-stability tracking.
module tb_iq_burst_framer;

  localparam int SR = 132;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = 8'd0;
  logic [31:0] set_data = 32'd0;
  logic [31:0] i_tdata = 32'd0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        busy;
  logic        burst_done;
  logic [31:0] rb_pkt_count;

  iq_burst_framer #(.WIDTH(32), .SR_BASE(SR)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .busy(busy), .burst_done(burst_done), .rb_pkt_count(rb_pkt_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] src = 32'd0;
  logic [31:0] exp_out = 32'd0;
  int          beats, cur_len, bd_cnt, seq_err, stall_err;
  int          pkt_len[$];
  logic        rdy_seen;
  logic        rand_rdy = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat;
  logic        prev_last;
  logic [31:0] rb_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe at negedge, then advance the source after the edge.
  task automatic step();
    logic in_hs;
    @(negedge clk);
    if (i_tready === 1'b1) rdy_seen = 1'b1;
    if (burst_done === 1'b1) bd_cnt++;
    if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== prev_dat || o_tlast !== prev_last))
      stall_err++;
    prev_stall = (o_tvalid === 1'b1) && (o_tready === 1'b0);
    prev_dat   = o_tdata;
    prev_last  = o_tlast;
    in_hs = (i_tvalid === 1'b1) && (i_tready === 1'b1);
    if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
      if (o_tdata !== exp_out) seq_err++;
      exp_out = exp_out + 32'd1;
      beats++;
      cur_len++;
      if (o_tlast === 1'b1) begin
        pkt_len.push_back(cur_len);
        cur_len = 0;
      end
    end
    @(posedge clk);
    #1;
    if (in_hs) begin
      src = src + 32'd1;
      i_tdata = src;
    end
    if (rand_rdy) o_tready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_addr = a;
    set_data = d;
    set_stb  = 1'b1;
    step();
    set_stb  = 1'b0;
  endtask

  task automatic scn_reset();
    beats = 0; cur_len = 0; bd_cnt = 0; seq_err = 0; stall_err = 0;
    rdy_seen = 1'b0;
    pkt_len.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      step();
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_until(input string tag, input int target);
    int n = 0;
    while (beats < target && n < 3000) begin
      step();
      n++;
    end
    chk(tag, 32'(beats >= target), 32'd1);
  endtask

  function automatic int count_len(input int len);
    int c = 0;
    foreach (pkt_len[i]) if (pkt_len[i] == len) c++;
    return c;
  endfunction

  initial begin
    i_tvalid = 1'b1;
    scn_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_i_tready",   {31'd0, i_tready},   32'd0);
    chk("rst_o_tvalid",   {31'd0, o_tvalid},   32'd0);
    chk("rst_o_tlast",    {31'd0, o_tlast},    32'd0);
    chk("rst_o_tdata",    o_tdata,             32'd0);
    chk("rst_busy",       {31'd0, busy},       32'd0);
    chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
    chk("rst_rb",         rb_pkt_count,        32'd0);
    reset = 1'b0;
    step();
    step();

    // SPP written as 0 behaves as 1: every beat is a packet.
    wr(8'(SR + 0), 32'd0);
    wr(8'(SR + 1), 32'd5);
    scn_reset();
    wr(8'(SR + 2), 32'd1);
    wait_idle("s1_idle");
    chk("s1_beats",     32'(beats), 32'd5);
    chk("s1_all_tlast", 32'(count_len(1)), 32'd5);
    chk("s1_bdone",     32'(bd_cnt), 32'd1);

    // Finite burst of three 100-sample packets.
    wr(8'(SR + 0), 32'd100);
    wr(8'(SR + 1), 32'd3);
    scn_reset();
    wr(8'(SR + 2), 32'd1);
    wait_idle("s2_idle");
    chk("s2_beats",   32'(beats), 32'd300);
    chk("s2_pkts100", 32'(count_len(100)), 32'd3);
    chk("s2_npkts",   32'(pkt_len.size()), 32'd3);
    chk("s2_bdone",   32'(bd_cnt), 32'd1);
    rdy_seen = 1'b0;
    repeat (20) step();
    chk("s2_rdy_low", {31'd0, rdy_seen}, 32'd0);

    // Continuous run stopped mid packet 5.
    wr(8'(SR + 0), 32'd64);
    wr(8'(SR + 1), 32'd0);
    scn_reset();
    wr(8'(SR + 2), 32'd1);
    run_until("s3_reach", 4 * 64 + 10);
    wr(8'(SR + 2), 32'd2);
    wait_idle("s3_idle");
    chk("s3_beats",  32'(beats), 32'd320);
    chk("s3_pkts64", 32'(count_len(64)), 32'd5);
    chk("s3_bdone",  32'(bd_cnt), 32'd0);

    // 30% downstream ready, SPP 37, four packets.
    wr(8'(SR + 0), 32'd37);
    wr(8'(SR + 1), 32'd4);
    scn_reset();
    rand_rdy = 1'b1;
    wr(8'(SR + 2), 32'd1);
    wait_idle("s4_idle");
    rand_rdy = 1'b0;
    o_tready = 1'b1;
    chk("s4_beats",   32'(beats), 32'd148);
    chk("s4_pkts37",  32'(count_len(37)), 32'd4);
    chk("s4_seq_err", 32'(seq_err), 32'd0);
    chk("s4_stable",  32'(stall_err), 32'd0);
    chk("s4_bdone",   32'(bd_cnt), 32'd1);

    // SPP rewritten mid packet 2 only affects packet 3 onward.
    wr(8'(SR + 0), 32'd50);
    wr(8'(SR + 1), 32'd0);
    scn_reset();
    wr(8'(SR + 2), 32'd1);
    run_until("s5_reach_p2", 55);
    wr(8'(SR + 0), 32'd20);
    run_until("s5_reach_p3", 120);
    wr(8'(SR + 2), 32'd2);
    wait_idle("s5_idle");
    chk("s5_pkt1", 32'(pkt_len[0]), 32'd50);
    chk("s5_pkt2", 32'(pkt_len[1]), 32'd50);
    chk("s5_pkt3", 32'(pkt_len[2]), 32'd20);
    chk("s5_seq_err", 32'(seq_err), 32'd0);

    // Start and stop together from IDLE does nothing.
    scn_reset();
    wr(8'(SR + 2), 32'd3);
    repeat (5) step();
    chk("s6_busy",  {31'd0, busy}, 32'd0);
    chk("s6_rdy",   {31'd0, rdy_seen}, 32'd0);
    chk("s6_beats", 32'(beats), 32'd0);

    // Packet statistics over seven packets, then flushed by clear.
`ifdef IQ_BURST_FRAMER_STATS_EN
    rb_exp = 32'd7;
`else
    rb_exp = 32'd0;
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    wr(8'(SR + 0), 32'd4);
    wr(8'(SR + 1), 32'd7);
    scn_reset();
    wr(8'(SR + 2), 32'd1);
    wait_idle("s7_idle");
    chk("s7_beats", 32'(beats), 32'd28);
    chk("s7_rb_run", rb_pkt_count, rb_exp);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("s7_rb_clr", rb_pkt_count, 32'd0);
    chk("s7_seq_err", 32'(seq_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iq_burst_framer.md
# iq_burst_framer

Downstream framing stage for the RFNoC sine tone generator. Consumes the generator's continuous 32-bit I/Q AXI-Stream, discards its tlast, and re-frames samples into packets of a programmable samples-per-packet (SPP), optionally limited to a programmable burst of N packets. Start and stop are software-controlled over the settings bus. Output is a registered, full-throughput AXI-Stream for the downstream packetizer.

## Interface
Parameters:
- WIDTH, 32: sample width, {Q[31:16], I[15:0]}.
- SR_BASE, 132: first settings address. SR_BASE is SPP, SR_BASE+1 is BURST_LEN, SR_BASE+2 is CTRL.

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; config registers retained.
- set_stb  in  1  settings write strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  WIDTH  input sample.
- i_tlast  in  1  ignored.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  framed sample.
- o_tlast  out  1  last sample of packet.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- busy  out  1  high while not IDLE.
- burst_done  out  1  one-cycle pulse when a finite burst completes.
- rb_pkt_count  out  32  completed-packet count (see Configuration).

## Operation
- Registers:
  - SPP[15:0]: a write of 0 is stored as 1. Reset value 16.
  - BURST_LEN[15:0]: 0 means continuous. Reset value 0.
  - CTRL: bit0 start, bit1 stop. Both are self-clearing strobes.
- Shadowing: SPP and BURST_LEN are latched into working copies at start and at every packet boundary. A mid-packet write never alters the current packet.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE to RUN on start. Load working copies; clear the sample and packet counters.
  - RUN to STOPPING on stop.
  - RUN or STOPPING to IDLE when the packet ends (sample_cnt == SPP-1 accepted) and either the state is STOPPING or the packet count reaches BURST_LEN (BURST_LEN ≠ 0). burst_done pulses only in the BURST_LEN case.
- Simultaneous strobes: start and stop in one write means stop wins. Start in RUN or STOPPING is ignored. Stop in IDLE is ignored.
- In IDLE, i_tready = 0: the upstream generator stalls and no samples are dropped.
- A transfer counts when the input side is accepted (i_tvalid & i_tready).
  - sample_cnt wraps from SPP-1 to 0.
  - o_tlast is set on the sample where sample_cnt == SPP-1.
  - Counters are 16-bit; the packet counter saturates at 0xFFFF.
- clear: returns to IDLE, empties the output stage, zeroes counters and rb_pkt_count. SPP and BURST_LEN are kept.

## Timing
- Reset values: i_tready 0, o_tvalid 0, o_tlast 0, o_tdata 0, busy 0, burst_done 0, rb_pkt_count 0, state IDLE, SPP 16, BURST_LEN 0.
- Settings write at edge k takes effect at edge k+1. i_tready may assert from cycle k+1 after the start write.
- Latency: input accept to o_tvalid is 1 cycle.
- Throughput: 1 sample/clk under continuous o_tready.
- Output stage is a 2-entry skid buffer, so i_tready is registered and not combinationally dependent on o_tready.
- AXI rules: o_tdata and o_tlast are stable while o_tvalid & !o_tready. o_tvalid never drops without a handshake, except on reset or clear.
- On return to IDLE, samples already in the skid buffer still drain. busy deasserts once the buffer is empty.
- burst_done pulses in the cycle the final tlast sample is accepted on the input side.
- Asynchronous reset mid-packet leaves no partial-packet memory. A truncated packet is acceptable only across reset or clear.

## Configuration
- IQ_BURST_FRAMER_STATS_EN defined: rb_pkt_count increments on each output handshake with o_tlast. It wraps at 2^32 and is cleared by reset or clear.
- Not defined: rb_pkt_count is tied to 0 and no counter logic is synthesized.

## Structure
- Shared package iq_burst_framer_pkg holds:
  - the state enum (IDLE/RUN/STOPPING);
  - register offset constants SPP_OFS=0, BURST_OFS=1, CTRL_OFS=2;
  - CTRL bit indices;
  - SPP_RESET=16.
- One sub-module, iq_framer_skid: a 2-entry AXI-Stream skid buffer of width WIDTH+1 (data plus tlast). The FSM, counters and settings decode stay in the top.

## Test plan
- Reset, then SPP=0 written and start: every output beat has o_tlast=1 (SPP clamped to 1).
- SPP=100, BURST_LEN=3, start, tone source running: exactly 300 beats with tlast on beats 99, 199 and 299. burst_done pulses once, busy falls, i_tready stays 0 afterwards.
- SPP=64, BURST_LEN=0, start, stop issued at beat 10 of packet 5: packet 5 completes at 64 beats, then IDLE. Total is 320 beats and burst_done never pulses.
- Random o_tready at 30% duty with SPP=37: output data sequence equals input sequence, no loss or duplication, tlast every 37th beat, data stable while stalled.
- SPP changed from 50 to 20 during packet 2 of a continuous run: packet 2 is 50 beats and packet 3 is 20 beats. Start and stop in a single write from IDLE: nothing happens.
- With IQ_BURST_FRAMER_STATS_EN, run 7 packets then pulse clear: rb_pkt_count reads 7, then 0. Without the macro it reads 0 throughout.
